// File: rtl/cga_alu_pkg.sv
// Shared definitions for the RALU result/shift stage.
//   shift_mode_e : shift fill mode (zero-in, rotate, arithmetic, link)
//   state_e      : sequencer state (IDLE -> LOAD -> SHIFT -> IDLE)
package cga_alu_pkg;

  typedef enum logic [1:0] {
    MODE_ZIN   = 2'b00,
    MODE_ROT   = 2'b01,
    MODE_ARITH = 2'b10,
    MODE_LINK  = 2'b11
  } shift_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10
  } state_e;

endpackage

// File: rtl/cga_alu_shift_step.sv
// Combinational one-bit shift step for the result stage.
// The word is always presented as the pair {R,RD}. In single mode only the
// high half (R) moves and the low half passes through untouched.
// Ports:
//   w       in   2*WIDTH  current {R,RD}
//   dir     in   1        1 = right step, 0 = left step
//   mode    in   2        fill mode (shift_mode_e)
//   m       in   1        current link bit
//   dbl     in   1        1 = shift the full 2*WIDTH pair
//   w_next  out  2*WIDTH  {R,RD} after the step
//   out_bit out  1        bit shifted out (becomes the new link bit)
module cga_alu_shift_step
  import cga_alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2*WIDTH-1:0] w,
  input  logic               dir,
  input  shift_mode_e        mode,
  input  logic               m,
  input  logic               dbl,
  output logic [2*WIDTH-1:0] w_next,
  output logic               out_bit
);

  logic msb_bit;
  logic lsb_bit;
  logic in_bit;

  // The msb is the same bit in both modes; the lsb of a single word is R[0].
  assign msb_bit = w[2*WIDTH-1];
  assign lsb_bit = dbl ? w[0] : w[WIDTH];

  // NOTE: every output of a combinational block gets a default first so a
  // missed branch can never infer a latch.
  always_comb begin
    in_bit = 1'b0;
    case (mode)
      MODE_ZIN:   in_bit = 1'b0;
      MODE_ROT:   in_bit = dir ? lsb_bit : msb_bit;
      MODE_ARITH: in_bit = dir ? msb_bit : 1'b0;
      MODE_LINK:  in_bit = m;
      default:    in_bit = 1'b0;
    endcase
  end

  always_comb begin
    w_next  = w;
    out_bit = dir ? lsb_bit : msb_bit;
    if (dbl) begin
      w_next = dir ? {in_bit, w[2*WIDTH-1:1]} : {w[2*WIDTH-2:0], in_bit};
    end else begin
      w_next[2*WIDTH-1:WIDTH] = dir ? {in_bit, w[2*WIDTH-1:WIDTH+1]}
                                    : {w[2*WIDTH-2:WIDTH], in_bit};
    end
  end

endmodule

// File: rtl/cga_alu_shift_seq.sv
// RALU result/shift stage. Captures the RALU result and flags on LD, then
// shifts R (or the pair R:RD) one bit per clock under a signed count.
// Negative counts shift right; the magnitude -32 maps to 32 steps.
// Ports:
//   sysclk, sys_rst_n   clock, asynchronous active-low reset
//   LD, ABORT           load strobe (IDLE only), cancel of an active shift
//   F_15_0, FD_15_0     high / low word to capture (FD only when DBL=1)
//   CRY_IN, OVF_IN,
//   SGR_IN, M_IN        RALU flags and link bit to capture
//   SHCNT_5_0           signed shift count
//   MODE_1_0, DBL       fill mode, double-word select
//   BUSY, DONE          active flag, one-cycle result-valid pulse
//   R_15_0, RD_15_0     shifted result, high / low word
//   C, O, Q, Z, M_OUT   carry, overflow, sign-greater, zero, link status
module cga_alu_shift_seq
  import cga_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 6
) (
  input  logic             sysclk,
  input  logic             sys_rst_n,
  input  logic             LD,
  input  logic             ABORT,
  input  logic [WIDTH-1:0] F_15_0,
  input  logic [WIDTH-1:0] FD_15_0,
  input  logic             CRY_IN,
  input  logic             OVF_IN,
  input  logic             SGR_IN,
  input  logic             M_IN,
  input  logic [CNT_W-1:0] SHCNT_5_0,
  input  logic [1:0]       MODE_1_0,
  input  logic             DBL,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] R_15_0,
  output logic [WIDTH-1:0] RD_15_0,
  output logic             C,
  output logic             O,
  output logic             Q,
  output logic             Z,
  output logic             M_OUT
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e              state;
  logic [CNT_W-1:0]    n_left;
  logic                dir_q;
  shift_mode_e         mode_q;
  logic                dbl_q;

  logic [CNT_W-1:0]    cnt_mag;
  logic [2*WIDTH-1:0]  load_w;
  logic [2*WIDTH-1:0]  step_w;
  logic                step_out;

  // Two's-complement magnitude; the most negative count (-32) stays 100000,
  // which read unsigned is exactly 32 steps.
  assign cnt_mag = SHCNT_5_0[CNT_W-1] ? (~SHCNT_5_0 + CNT_ONE) : SHCNT_5_0;

  // Low word is forced to zero in single mode so {R,RD}==0 is the zero test
  // for both widths.
  assign load_w = {F_15_0, (DBL ? FD_15_0 : {WIDTH{1'b0}})};

  cga_alu_shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .w       ({R_15_0, RD_15_0}),
    .dir     (dir_q),
    .mode    (mode_q),
    .m       (M_OUT),
    .dbl     (dbl_q),
    .w_next  (step_w),
    .out_bit (step_out)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      n_left  <= '0;
      dir_q   <= 1'b0;
      mode_q  <= MODE_ZIN;
      dbl_q   <= 1'b0;
      R_15_0  <= '0;
      RD_15_0 <= '0;
      C       <= 1'b0;
      O       <= 1'b0;
      Q       <= 1'b0;
      Z       <= 1'b1;
      M_OUT   <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (LD) begin
            {R_15_0, RD_15_0} <= load_w;
            C      <= CRY_IN;
            O      <= OVF_IN;
            Q      <= SGR_IN;
            M_OUT  <= M_IN;
            Z      <= (load_w == '0);
            dir_q  <= SHCNT_5_0[CNT_W-1];
            n_left <= cnt_mag;
            mode_q <= shift_mode_e'(MODE_1_0);
            dbl_q  <= DBL;
            BUSY   <= 1'b1;
            state  <= LOAD;
          end
        end

        LOAD: begin
          if (ABORT) begin
            BUSY  <= 1'b0;
            state <= IDLE;
          end else if (n_left == '0) begin
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= IDLE;
          end else begin
            state <= SHIFT;
          end
        end

        SHIFT: begin
          // ABORT takes priority over the step, including the final one, so
          // an aborted result is never reported as done.
          if (ABORT) begin
            BUSY  <= 1'b0;
            state <= IDLE;
          end else begin
            {R_15_0, RD_15_0} <= step_w;
            M_OUT  <= step_out;
            Z      <= (step_w == '0);
            n_left <= n_left - CNT_ONE;
            if (n_left == CNT_ONE) begin
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
              state <= IDLE;
            end
          end
        end

        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cga_alu_shift_seq.sv
// Scoreboard bench for cga_alu_shift_seq: each load pushes the hand-computed
// result and the cycle DONE is due; a monitor compares on every DONE.
module tb_cga_alu_shift_seq;

  logic        sysclk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        LD = 1'b0;
  logic        ABORT = 1'b0;
  logic [15:0] F_15_0 = '0;
  logic [15:0] FD_15_0 = '0;
  logic        CRY_IN = 1'b0;
  logic        OVF_IN = 1'b0;
  logic        SGR_IN = 1'b0;
  logic        M_IN = 1'b0;
  logic [5:0]  SHCNT_5_0 = '0;
  logic [1:0]  MODE_1_0 = '0;
  logic        DBL = 1'b0;
  logic        BUSY, DONE, C, O, Q, Z, M_OUT;
  logic [15:0] R_15_0, RD_15_0;

  cga_alu_shift_seq dut (
    .sysclk    (sysclk),
    .sys_rst_n (sys_rst_n),
    .LD        (LD),
    .ABORT     (ABORT),
    .F_15_0    (F_15_0),
    .FD_15_0   (FD_15_0),
    .CRY_IN    (CRY_IN),
    .OVF_IN    (OVF_IN),
    .SGR_IN    (SGR_IN),
    .M_IN      (M_IN),
    .SHCNT_5_0 (SHCNT_5_0),
    .MODE_1_0  (MODE_1_0),
    .DBL       (DBL),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .R_15_0    (R_15_0),
    .RD_15_0   (RD_15_0),
    .C         (C),
    .O         (O),
    .Q         (Q),
    .Z         (Z),
    .M_OUT     (M_OUT)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    int          tag;
    logic [15:0] r;
    logic [15:0] rd;
    logic        c, o, q, z, m;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every DONE must match the oldest outstanding expectation.
  always @(negedge sysclk) begin
    if (sys_rst_n && DONE) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got DONE=1 at cycle %0d expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("t%0d_cycle", mon_e.tag), cyc, mon_e.done_cyc);
        check($sformatf("t%0d_r", mon_e.tag), {16'h0, R_15_0}, {16'h0, mon_e.r});
        check($sformatf("t%0d_rd", mon_e.tag), {16'h0, RD_15_0}, {16'h0, mon_e.rd});
        check($sformatf("t%0d_flags_cozqm", mon_e.tag), {27'h0, C, O, Z, Q, M_OUT},
              {27'h0, mon_e.c, mon_e.o, mon_e.z, mon_e.q, mon_e.m});
        check($sformatf("t%0d_busy", mon_e.tag), {31'h0, BUSY}, 32'h0);
      end
    end
  end

  // Issues one load. Returns one cycle after LD, with LD dropped again.
  task automatic send(input int tag, input logic [15:0] f, input logic [15:0] fd,
                      input logic cry, input logic ovf, input logic sgr, input logic m_in,
                      input logic [5:0] cnt, input logic [1:0] mode, input logic dbl,
                      input bit expect_done,
                      input logic [15:0] er, input logic [15:0] erd,
                      input logic ec, input logic eo, input logic eq,
                      input logic ez, input logic em, input int lat);
    exp_t e;
    @(posedge sysclk); #1;
    F_15_0 = f; FD_15_0 = fd; CRY_IN = cry; OVF_IN = ovf; SGR_IN = sgr; M_IN = m_in;
    SHCNT_5_0 = cnt; MODE_1_0 = mode; DBL = dbl; LD = 1'b1;
    if (expect_done) begin
      e.tag = tag; e.r = er; e.rd = erd; e.c = ec; e.o = eo; e.q = eq; e.z = ez; e.m = em;
      e.done_cyc = cyc + lat;
      sb.push_back(e);
    end
    @(posedge sysclk); #1;
    LD = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(posedge sysclk);
      k++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    repeat (3) @(posedge sysclk);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_busy"}, {31'h0, BUSY}, 32'h0);
    check({pfx, "_done"}, {31'h0, DONE}, 32'h0);
    check({pfx, "_r_rd"}, {R_15_0, RD_15_0}, 32'h0);
    check({pfx, "_flags_cozqm"}, {27'h0, C, O, Z, Q, M_OUT}, 32'h4);
  endtask

  initial begin
    #12;
    check_reset_values("reset");
    @(posedge sysclk); #1;
    sys_rst_n = 1'b1;

    // tag f fd cry ovf sgr m cnt mode dbl exp | r rd c o q z m lat
    send(1, 16'h8001, 16'h0, 0, 0, 0, 0, 6'h01, 2'b00, 0, 1, 16'h0002, 16'h0, 0, 0, 0, 0, 1, 3);
    wait_drain(50);
    send(2, 16'h8001, 16'h0, 0, 0, 1, 0, 6'h3C, 2'b10, 0, 1, 16'hF800, 16'h0, 0, 0, 1, 0, 0, 6);
    wait_drain(50);
    // Low bit of R moves into RD[15]; the bit shifted out is RD[0]=0.
    send(3, 16'h0001, 16'h0000, 0, 0, 0, 0, 6'h3F, 2'b01, 1, 1, 16'h0000, 16'h8000, 0, 0, 0, 0, 0, 3);
    wait_drain(50);
    // 17-bit rotate of {M,R}: 32 mod 17 = 15 right == 2 left of 1_00FF.
    send(4, 16'h00FF, 16'h0, 0, 0, 0, 1, 6'h20, 2'b11, 0, 1, 16'h03FE, 16'h0, 0, 0, 0, 0, 0, 34);
    wait_drain(80);

    // Zero count, flags pass through; a second LD while BUSY is dropped.
    send(5, 16'h1234, 16'h0, 1, 1, 0, 0, 6'h00, 2'b00, 0, 1, 16'h1234, 16'h0, 1, 1, 0, 0, 0, 2);
    check("t5_busy_in_load", {31'h0, BUSY}, 32'h1);
    F_15_0 = 16'hBEEF; LD = 1'b1;
    @(posedge sysclk); #1;
    LD = 1'b0;
    wait_drain(50);
    repeat (5) @(posedge sysclk);
    check("t5_r_after_ignored_ld", {16'h0, R_15_0}, 32'h1234);

    send(6, 16'hA5C3, 16'h0, 0, 0, 0, 0, 6'h10, 2'b01, 0, 1, 16'hA5C3, 16'h0, 0, 0, 0, 0, 1, 18);
    wait_drain(50);
    send(7, 16'hFFFF, 16'h0, 0, 0, 0, 0, 6'h14, 2'b00, 0, 1, 16'h0000, 16'h0, 0, 0, 0, 1, 0, 22);
    wait_drain(50);
    send(8, 16'h8000, 16'h0001, 0, 0, 0, 1, 6'h01, 2'b11, 1, 1, 16'h0000, 16'h0003, 0, 0, 0, 0, 1, 3);
    wait_drain(50);
    send(9, 16'h0000, 16'h0001, 0, 0, 0, 0, 6'h3F, 2'b00, 1, 1, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 3);
    wait_drain(50);

    // ABORT mid-shift after two steps: partial value kept, no DONE.
    send(10, 16'h0001, 16'h0, 0, 0, 0, 0, 6'h08, 2'b00, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge sysclk);
    #1 ABORT = 1'b1;
    @(posedge sysclk); #1;
    ABORT = 1'b0;
    check("t10_busy_after_abort", {31'h0, BUSY}, 32'h0);
    check("t10_r_partial", {16'h0, R_15_0}, 32'h0004);
    repeat (12) @(posedge sysclk);

    // ABORT together with the final step: step dropped, no DONE.
    send(11, 16'h0001, 16'h0, 0, 0, 0, 0, 6'h02, 2'b00, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge sysclk);
    #1 ABORT = 1'b1;
    @(posedge sysclk); #1;
    ABORT = 1'b0;
    check("t11_busy_after_abort", {31'h0, BUSY}, 32'h0);
    check("t11_r_partial", {16'h0, R_15_0}, 32'h0002);

    // ABORT while idle changes nothing.
    ABORT = 1'b1;
    repeat (2) @(posedge sysclk);
    #1 ABORT = 1'b0;
    check("t12_idle_abort_r", {16'h0, R_15_0}, 32'h0002);
    check("t12_idle_abort_busy", {31'h0, BUSY}, 32'h0);

    // Reset mid-shift: outputs return to reset values at once.
    send(13, 16'h5555, 16'h0, 1, 1, 1, 1, 6'h0A, 2'b01, 0, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 0);
    repeat (4) @(posedge sysclk);
    #3 sys_rst_n = 1'b0;
    #1 check_reset_values("t13_reset");
    @(posedge sysclk); #1;
    sys_rst_n = 1'b1;

    // Recovery after reset.
    send(14, 16'h8001, 16'h0, 0, 0, 0, 0, 6'h01, 2'b00, 0, 1, 16'h0002, 16'h0, 0, 0, 0, 0, 1, 3);
    wait_drain(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
